lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator that sits between the MEM pipeline stage and the data RAM port (mem_ctrl, wr_addr, wr_data, rd_addr, rd_ready, wr_ready, rd_data).
- Accepts one memory op at a time from the pipeline and checks alignment and address range.
- Issues the access to the RAM and waits for the ready handshake, with a timeout.
- Returns sign- or zero-extended load data, or an error code, as a one-cycle response pulse.
- Holds busy high so the pipeline stalls while an access is in flight.

Parameters:
- ADDR_BITS, 7: RAM byte-address width. Any address with a nonzero bit in [31:ADDR_BITS] is a range fault.
- TIMEOUT, 15: maximum cycles spent in ISSUE+WAIT before a timeout error. Range 1..255.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  pipeline request strobe.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  op code per defines.vh: NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=9, SH=10, SW=11. Bit 3 set means store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores, errors and NONE.
- resp_err  out  2  00 ok, 01 misaligned, 10 range, 11 timeout.
- busy  out  1  high in every state except IDLE.
- mem_ctrl  out  4  op driven to RAM; NONE when not issuing.
- rd_addr  out  32  load address to RAM.
- wr_addr  out  32  store address to RAM.
- wr_data  out  32  store data to RAM.
- rd_ready  in  1  RAM load-data valid; rd_data is combinational from the RAM.
- wr_ready  in  1  RAM store done; registered, one cycle after the write edge.
- rd_data  in  32  RAM load data.

Behaviour:
- Reset values: state=IDLE, mem_ctrl=NONE, rd_addr/wr_addr/wr_data=0, resp_valid=0, resp_rdata=0, resp_err=00, busy=0, timeout counter=0.
- Reset mid-operation aborts the access with no response. A store whose ISSUE edge already occurred stays written.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, addr and wdata.
  - Illegal op codes (6,7,8,12-15) are treated as NONE.
  - NONE -> RESP, err 00, no bus activity.
  - Misaligned -> RESP, err 01, no bus activity. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Range fault -> RESP, err 10, no bus activity. Misalignment takes priority over range.
  - Otherwise -> ISSUE; counter cleared.
- ISSUE, load:
  - mem_ctrl=op, rd_addr=addr.
  - If rd_ready=1, capture rd_data and go to RESP.
  - Otherwise stay in ISSUE holding outputs, counter++.
- ISSUE, store:
  - mem_ctrl=op, wr_addr=addr, wr_data=wdata for exactly one cycle, so the RAM write edge occurs once. Then -> WAIT.
- WAIT (stores only):
  - mem_ctrl=NONE.
  - wr_ready=1 -> RESP, err 00. Otherwise counter++.
- Timeout: when the counter reaches TIMEOUT in ISSUE or WAIT -> RESP with err 11, mem_ctrl=NONE.
- RESP:
  - resp_valid=1 for one cycle, then -> IDLE.
  - req_ready=0, so back-to-back requests are spaced by at least one idle cycle.
- Load extension is done locally from the captured rd_data; the RAM's own extension is not trusted.
  - LB: sign-extend bits [7:0].
  - LBU: zero-extend bits [7:0].
  - LH: sign-extend bits [15:0].
  - LHU: zero-extend bits [15:0].
  - LW: pass all 32 bits.
- Latency, with the request accepted at edge N:
  - Load with rd_ready=1: resp_valid is high in the cycle after edge N+1.
  - Store: resp_valid is high in the cycle after edge N+2.
  - Error or NONE: resp_valid is high in the cycle after edge N.
- Simultaneous events: req_valid outside IDLE is ignored (no latch). A wr_ready arriving during ISSUE is ignored.

Decomposition:
- defines.vh (shared):
  - op codes LB..SW and NONE, plus the store-bit index.
  - resp_err codes.
  - FSM state encodings.
- One natural sub-module, lsu_load_extend: combinational (op, raw32) -> extended32. It is reused by future cache-fill logic.

Test Plan:
1. LW at addr 0x10, RAM rd_data=0x8899AABB with rd_ready=1 -> resp_valid 2 cycles after accept, resp_rdata=0x8899AABB, err 00.
2. LB at addr 0x03 with rd_data=0x000000F0 -> 0xFFFFFFF0. LBU at the same address -> 0x000000F0. LH with rd_data=0x00008001 -> 0xFFFF8001.
3. SW addr 0x20, data 0xDEADBEEF -> mem_ctrl=SW for exactly 1 cycle, then NONE. wr_ready next cycle. resp err 00. A following LW at 0x20 returns 0xDEADBEEF.
4. LH at addr 0x05 -> err 01, mem_ctrl stays NONE. SW at 0x00000080 -> err 10, no write.
5. LW with rd_ready held 0 and TIMEOUT=15 -> resp err 11 after 15 ISSUE cycles, mem_ctrl returns to NONE.
6. rst asserted during WAIT of an SB -> next cycle IDLE, busy=0, no resp_valid. req_valid held high during RESP is not accepted until IDLE.

Source files
------------

// File: rtl/lsu_mem_master_pkg.sv
// Shared op codes, error codes, FSM encoding and request-decode helpers for the LSU.
// Combinational helpers only; no latency, no flow control.
// Backpressure: not applicable.
package lsu_mem_master_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LW   = 4'd3;
    localparam logic [3:0] OP_LBU  = 4'd4;
    localparam logic [3:0] OP_LHU  = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd9;
    localparam logic [3:0] OP_SH   = 4'd10;
    localparam logic [3:0] OP_SW   = 4'd11;
    localparam int         STORE_BIT = 3;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Unknown encodings collapse to NONE so they never reach the RAM.
    function automatic logic [3:0] op_sanitize(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: return op;
            default:             return OP_NONE;
        endcase
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return addr_lo[0];
            OP_LW, OP_SW:         return addr_lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of raw 32-bit load data according to the load op.
// Purely combinational, zero latency.
// Backpressure: not applicable.
module lsu_load_extend
    import lsu_mem_master_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] raw_i,
    output logic [31:0] ext_o
);

    always_comb begin
        ext_o = raw_i;
        case (op_i)
            OP_LB:   ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
            OP_LBU:  ext_o = {24'd0, raw_i[7:0]};
            OP_LH:   ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
            OP_LHU:  ext_o = {16'd0, raw_i[15:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator between the MEM stage and the data RAM port.
// Latency: error/NONE 1 cycle, load 2+ cycles, store 3+ cycles to the resp_valid pulse.
// Backpressure: req_ready only in IDLE; busy stalls the pipeline until the response pulse.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter int ADDR_BITS = 7,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        busy,
    output logic [3:0]  mem_ctrl,
    output logic [31:0] rd_addr,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    input  logic        rd_ready,
    input  logic        wr_ready,
    input  logic [31:0] rd_data
);

    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;

    logic [3:0]  req_op_s;
    logic        req_misal;
    logic        req_range;
    logic        tmo_hit;
    logic [31:0] ld_ext;

    assign req_op_s  = op_sanitize(req_op);
    assign req_misal = op_misaligned(req_op_s, req_addr[1:0]);
    assign req_range = (req_addr >> ADDR_BITS) != 32'd0;
    assign tmo_hit   = (cnt_q + 8'd1) == TMO_LIM;

    lsu_load_extend u_load_extend (
        .op_i  (op_q),
        .raw_i (rd_data),
        .ext_o (ld_ext)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op_s;
                    cnt_d   = 8'd0;
                    rdata_d = 32'd0;
                    err_d   = ERR_OK;
                    state_d = ST_RESP;
                    // Misalignment is checked before range so it wins when both apply.
                    if (req_op_s != OP_NONE) begin
                        if (req_misal) begin
                            err_d = ERR_MISALIGN;
                        end else if (req_range) begin
                            err_d = ERR_RANGE;
                        end else begin
                            state_d = ST_ISSUE;
                            if (req_op_s[STORE_BIT]) begin
                                wr_addr_d = req_addr;
                                wr_data_d = req_wdata;
                            end else begin
                                rd_addr_d = req_addr;
                            end
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (!op_q[STORE_BIT] && rd_ready) begin
                    rdata_d = ld_ext;
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_RESP;
                end else begin
                    // A store drives the RAM for this single cycle only.
                    cnt_d   = cnt_q + 8'd1;
                    state_d = op_q[STORE_BIT] ? ST_WAIT : ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (wr_ready) begin
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NONE;
            cnt_q     <= 8'd0;
            rd_addr_q <= 32'd0;
            wr_addr_q <= 32'd0;
            wr_data_q <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= ERR_OK;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign req_ready  = state_q == ST_IDLE;
    assign busy       = state_q != ST_IDLE;
    assign resp_valid = state_q == ST_RESP;
    assign mem_ctrl   = (state_q == ST_ISSUE) ? op_q : OP_NONE;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign rd_addr    = rd_addr_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed vector table, hand-written corner sequences and
// randomized ops against a byte-array reference model, with a small RAM model on the port.
module tb_lsu_mem_master;

    localparam logic [3:0] LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4, LHU = 4'd5;
    localparam logic [3:0] SB = 4'd9, SH = 4'd10, SW = 4'd11;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        busy;
    logic [3:0]  mem_ctrl;
    logic [31:0] rd_addr, wr_addr, wr_data, rd_data;
    logic        rd_ready, wr_ready;

    logic        rd_ready_en, wr_ready_en, rd_force;
    logic [31:0] rd_force_val;
    logic        pend, wr_ready_r;
    int          bus_cyc, wr_cnt;
    int          n_cmp, n_bad;
    logic [7:0]  ram_b [128] = '{default: 8'h00};
    logic [7:0]  ref_b [128] = '{default: 8'h00};

    typedef struct {
        logic [31:0] r;
        logic [1:0]  e;
        int          lat;
        int          bus;
        int          wr;
        logic [3:0]  mc;
    } res_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          frc;
        logic [31:0] fval;
        logic [31:0] x_r;
        logic [1:0]  x_e;
        int          x_lat;
        int          x_bus;
    } vec_t;

    vec_t tv [21];

    lsu_mem_master #(.ADDR_BITS(7), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .mem_ctrl   (mem_ctrl),
        .rd_addr    (rd_addr),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_ready   (rd_ready),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read with the addressed byte lane shifted down to bit 0.
    assign rd_ready = rd_ready_en;
    assign wr_ready = wr_ready_r;

    always_comb begin
        logic [6:0]  a;
        logic [31:0] w;
        a = rd_addr[6:0];
        w = {ram_b[{a[6:2], 2'd3}], ram_b[{a[6:2], 2'd2}], ram_b[{a[6:2], 2'd1}], ram_b[{a[6:2], 2'd0}]};
        if (rd_force)
            rd_data = rd_force_val;
        else if (rd_addr[31:7] != 25'd0)
            rd_data = 32'hBAD0BAD0;
        else
            rd_data = w >> {a[1:0], 3'b000};
    end

    always @(negedge clk) begin
        if (mem_ctrl != 4'd0) bus_cyc <= bus_cyc + 1;
        pend <= (mem_ctrl == SB) || (mem_ctrl == SH) || (mem_ctrl == SW);
        if ((mem_ctrl == SB || mem_ctrl == SH || mem_ctrl == SW) && wr_addr[31:7] == 25'd0) begin
            wr_cnt <= wr_cnt + 1;
            ram_b[wr_addr[6:0]] <= wr_data[7:0];
            if (mem_ctrl != SB) ram_b[wr_addr[6:0] + 7'd1] <= wr_data[15:8];
            if (mem_ctrl == SW) begin
                ram_b[wr_addr[6:0] + 7'd2] <= wr_data[23:16];
                ram_b[wr_addr[6:0] + 7'd3] <= wr_data[31:24];
            end
        end
    end

    always @(posedge clk) begin
        wr_ready_r <= pend && wr_ready_en;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, little-endian, spec-level rules only.
    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output res_t x);
        int          sz;
        bit          ld, sgn;
        logic [31:0] v;
        x = '{r: 32'd0, e: 2'd0, lat: 0, bus: 0, wr: 0, mc: 4'd0};
        sz = 0; ld = 0; sgn = 0; v = 32'd0;
        case (op)
            LB:  begin sz = 1; ld = 1; sgn = 1; end
            LH:  begin sz = 2; ld = 1; sgn = 1; end
            LW:  begin sz = 4; ld = 1; end
            LBU: begin sz = 1; ld = 1; end
            LHU: begin sz = 2; ld = 1; end
            SB:  sz = 1;
            SH:  sz = 2;
            SW:  sz = 4;
            default: sz = 0;
        endcase
        if (sz == 0) return;
        if (addr % sz != 0) x.e = 2'd1;
        else if (addr >= 32'd128) x.e = 2'd2;
        else if (ld) begin
            for (int k = 0; k < sz; k++) v = v | (32'(ref_b[int'(addr) + k]) << (8 * k));
            if (sgn && v[8 * sz - 1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
            x.r = v; x.lat = 1; x.bus = 1;
        end else begin
            for (int k = 0; k < sz; k++) ref_b[int'(addr) + k] = wdata[8 * k +: 8];
            x.lat = 2; x.bus = 1; x.wr = 1;
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output res_t res);
        int g, b0, w0;
        g = 0;
        @(negedge clk);
        while (!req_ready && g < 50) begin @(negedge clk); g++; end
        chk("req_ready_before_op", {31'd0, req_ready}, 32'd1);
        b0 = bus_cyc; w0 = wr_cnt;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        res.lat = 0;
        while (!resp_valid && res.lat < 60) begin @(posedge clk); #1; res.lat++; end
        res.r = resp_rdata; res.e = resp_err; res.mc = mem_ctrl;
        @(posedge clk); #1;
        chk("resp_pulse_len", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        res.bus = bus_cyc - b0; res.wr = wr_cnt - w0;
    endtask

    task automatic cmp_res(input string tag, input res_t a, input res_t x);
        chk({tag, ".rdata"}, a.r, x.r);
        chk({tag, ".err"}, {30'd0, a.e}, {30'd0, x.e});
        chk({tag, ".latency"}, 32'(a.lat), 32'(x.lat));
        chk({tag, ".bus_cycles"}, 32'(a.bus), 32'(x.bus));
        chk({tag, ".write_edges"}, 32'(a.wr), 32'(x.wr));
        chk({tag, ".mem_ctrl_at_resp"}, {28'd0, a.mc}, {28'd0, x.mc});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t a, x;
        logic [3:0]  op;
        logic [31:0] addr;

        n_cmp = 0; n_bad = 0; bus_cyc = 0; wr_cnt = 0; pend = 1'b0; wr_ready_r = 1'b0;
        rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'd0; req_wdata = 32'd0;
        rd_ready_en = 1'b1; wr_ready_en = 1'b1; rd_force = 1'b0; rd_force_val = 32'd0;

        tv[0]  = '{LW,   32'h10,        32'h0,        1, 32'h8899AABB, 32'h8899AABB, 2'd0, 1, 1};
        tv[1]  = '{LB,   32'h03,        32'h0,        1, 32'h000000F0, 32'hFFFFFFF0, 2'd0, 1, 1};
        tv[2]  = '{LBU,  32'h03,        32'h0,        1, 32'h000000F0, 32'h000000F0, 2'd0, 1, 1};
        tv[3]  = '{LH,   32'h02,        32'h0,        1, 32'h00008001, 32'hFFFF8001, 2'd0, 1, 1};
        tv[4]  = '{LHU,  32'h02,        32'h0,        1, 32'h00008001, 32'h00008001, 2'd0, 1, 1};
        tv[5]  = '{LB,   32'h7F,        32'h0,        1, 32'h1234567F, 32'h0000007F, 2'd0, 1, 1};
        tv[6]  = '{LH,   32'h05,        32'h0,        0, 32'h0,        32'h0,        2'd1, 0, 0};
        tv[7]  = '{SW,   32'h80,        32'hCAFEF00D, 0, 32'h0,        32'h0,        2'd2, 0, 0};
        tv[8]  = '{LW,   32'h81,        32'h0,        0, 32'h0,        32'h0,        2'd1, 0, 0};
        tv[9]  = '{LW,   32'h10000000,  32'h0,        0, 32'h0,        32'h0,        2'd2, 0, 0};
        tv[10] = '{4'd0, 32'h81,        32'h0,        0, 32'h0,        32'h0,        2'd0, 0, 0};
        tv[11] = '{4'd7, 32'h10,        32'h0,        0, 32'h0,        32'h0,        2'd0, 0, 0};
        tv[12] = '{4'd13, 32'h10,       32'h0,        0, 32'h0,        32'h0,        2'd0, 0, 0};
        tv[13] = '{SW,   32'h20,        32'hDEADBEEF, 0, 32'h0,        32'h0,        2'd0, 2, 1};
        tv[14] = '{LW,   32'h20,        32'h0,        0, 32'h0,        32'hDEADBEEF, 2'd0, 1, 1};
        tv[15] = '{SB,   32'h21,        32'h12345655, 0, 32'h0,        32'h0,        2'd0, 2, 1};
        tv[16] = '{LW,   32'h20,        32'h0,        0, 32'h0,        32'hDEAD55EF, 2'd0, 1, 1};
        tv[17] = '{LB,   32'h22,        32'h0,        0, 32'h0,        32'hFFFFFFAD, 2'd0, 1, 1};
        tv[18] = '{LHU,  32'h22,        32'h0,        0, 32'h0,        32'h0000DEAD, 2'd0, 1, 1};
        tv[19] = '{SH,   32'h7E,        32'h0000BEEF, 0, 32'h0,        32'h0,        2'd0, 2, 1};
        tv[20] = '{LH,   32'h7E,        32'h0,        0, 32'h0,        32'hFFFFBEEF, 2'd0, 1, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.resp_err", {30'd0, resp_err}, 32'd0);
        chk("rst.mem_ctrl", {28'd0, mem_ctrl}, 32'd0);
        chk("rst.rd_addr", rd_addr, 32'd0);
        chk("rst.wr_addr", wr_addr, 32'd0);
        chk("rst.wr_data", wr_data, 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            rd_force = tv[i].frc; rd_force_val = tv[i].fval;
            model(tv[i].op, tv[i].addr, tv[i].wdata, x);
            x.r = tv[i].x_r; x.e = tv[i].x_e; x.lat = tv[i].x_lat; x.bus = tv[i].x_bus;
            x.wr = (tv[i].op[3] && tv[i].x_bus != 0) ? 1 : 0;
            x.mc = 4'd0;
            do_op(tv[i].op, tv[i].addr, tv[i].wdata, a);
            cmp_res($sformatf("vec%0d", i), a, x);
        end
        rd_force = 1'b0;

        // Load timeout: 15 ISSUE cycles, RAM never ready.
        rd_ready_en = 1'b0;
        do_op(LW, 32'h10, 32'h0, a);
        x = '{r: 32'd0, e: 2'd3, lat: 15, bus: 15, wr: 0, mc: 4'd0};
        cmp_res("load_timeout", a, x);
        rd_ready_en = 1'b1;

        // Store timeout: the write still lands, only wr_ready is withheld.
        wr_ready_en = 1'b0;
        model(SW, 32'h40, 32'h0BADF00D, x);
        do_op(SW, 32'h40, 32'h0BADF00D, a);
        x = '{r: 32'd0, e: 2'd3, lat: 15, bus: 1, wr: 1, mc: 4'd0};
        cmp_res("store_timeout", a, x);
        model(LW, 32'h40, 32'h0, x);
        do_op(LW, 32'h40, 32'h0, a);
        cmp_res("load_after_tmo_store", a, x);

        // Reset while an SB sits in WAIT: no response, write persists.
        model(SB, 32'h31, 32'h5A5A5AA5, x);
        @(negedge clk);
        req_valid = 1'b1; req_op = SB; req_addr = 32'h31; req_wdata = 32'h5A5A5AA5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstwait.busy_issue", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("rstwait.mem_ctrl_wait", {28'd0, mem_ctrl}, 32'd0);
        chk("rstwait.busy_wait", {31'd0, busy}, 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rstwait.busy", {31'd0, busy}, 32'd0);
        chk("rstwait.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rstwait.resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk); rst = 1'b0; wr_ready_en = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rstwait.no_resp", {31'd0, resp_valid}, 32'd0);
        end
        model(LBU, 32'h31, 32'h0, x);
        do_op(LBU, 32'h31, 32'h0, a);
        cmp_res("rstwait.readback", a, x);

        // req_valid held through RESP must not be taken until IDLE.
        rd_force = 1'b1; rd_force_val = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b1; req_op = LH; req_addr = 32'h05;
        @(posedge clk); #1;
        chk("hold.resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("hold.err", {30'd0, resp_err}, 32'd1);
        req_op = LW; req_addr = 32'h10;
        @(posedge clk); #1;
        chk("hold.not_taken_in_resp", {31'd0, req_ready}, 32'd1);
        chk("hold.no_resp", {31'd0, resp_valid}, 32'd0);
        chk("hold.mem_ctrl_idle", {28'd0, mem_ctrl}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("hold.mem_ctrl_issue", {28'd0, mem_ctrl}, {28'd0, LW});
        chk("hold.busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("hold.resp2_valid", {31'd0, resp_valid}, 32'd1);
        chk("hold.resp2_rdata", resp_rdata, 32'h12345678);
        rd_force = 1'b0;

        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            else addr = 32'($urandom_range(0, 127));
            model(op, addr, $urandom, x);
            do_op(op, addr, req_wdata_last(x, op, addr), a);
            cmp_res($sformatf("rnd%0d", i), a, x);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // The store data used by the model for the last random op, replayed to the DUT.
    logic [31:0] last_wdata;
    function automatic logic [31:0] req_wdata_last(input res_t x, input logic [3:0] op, input logic [31:0] addr);
        logic [31:0] w;
        w = 32'd0;
        if (x.wr != 0 && addr < 32'd128) begin
            case (op)
                SB:      w = {24'd0, ref_b[int'(addr)]};
                SH:      w = {16'd0, ref_b[int'(addr) + 1], ref_b[int'(addr)]};
                default: w = {ref_b[int'(addr) + 3], ref_b[int'(addr) + 2], ref_b[int'(addr) + 1], ref_b[int'(addr)]};
            endcase
        end
        return w;
    endfunction

endmodule
